icache_line_refill: RTL and testbench
=====================================

Name: icache_line_refill

Overview:
- Direct-mapped instruction cache for the example core with multi-word lines.
- Sits between the fetch stage (cached_instr_* side) and the memory/bus instruction port (instr_* side).
- Misses fetch the full line from memory, critical word first. The first returned word is forwarded to the core as soon as it arrives.
- A flush input invalidates the whole cache, for fence.i.

Parameters:
INDEX_BITS, 6, number of lines = 2**INDEX_BITS
OFFSET_BITS, 2, words per line = 2**OFFSET_BITS; legal range 0..4

Ports:
clk  input  1  clock
res_n  input  1  asynchronous active-low reset
flush  input  1  single-cycle pulse; invalidate all lines
cached_instr_req  input  1  core fetch request; held high with stable address until cached_instr_valid
cached_instr_adr  input  32  fetch byte address; bits [1:0] ignored
cached_instr_valid  output  1  single-cycle pulse; cached_instr_read is valid
cached_instr_read  output  32  instruction word
instr_req  output  1  memory request; held high with stable instr_adr until instr_valid
instr_adr  output  32  word-aligned memory address
instr_valid  input  1  memory word returned, single-cycle
instr_read  input  32  memory read data

Behaviour:
- Clocking and reset: one clock, clk. Reset res_n is asynchronous and active-low.
- Address split:
  - offset = adr[OFFSET_BITS+1:2]
  - index = adr[INDEX_BITS+OFFSET_BITS+1:OFFSET_BITS+2]
  - tag = adr[31:INDEX_BITS+OFFSET_BITS+2]
- Storage:
  - Data array: 2**(INDEX_BITS+OFFSET_BITS) x 32.
  - Tag array: one tag per line, no reset.
  - Valid vector: one bit per line, cleared by reset.
- Reset (res_n=0, asynchronous):
  - state=IDLE; valids=0; word counter=0; discard flag=0.
  - All outputs 0.
  - Data and tag contents are not reset.
- IDLE:
  - req=1 and hit: go to HIT.
  - req=1 and miss: latch the base line address; counter=requested offset; go to REFILL.
  - Outputs 0.
- HIT:
  - cached_instr_valid=1; cached_instr_read=data[index,offset].
  - Next state IDLE.
  - Hit latency: valid in the cycle after req is first sampled high.
- REFILL:
  - instr_req=1; instr_adr={tag,index,counter,2'b00}.
  - On instr_valid: write the word to data[index,counter] and increment counter modulo 2**OFFSET_BITS (wrap).
  - The first word (counter == requested offset) is also driven combinationally to cached_instr_valid/cached_instr_read in the same cycle.
  - After the last word (counter returns to the start offset): write the tag, set valid[index]=1 unless discard=1, clear discard, go to IDLE.
  - instr_req stays high between words. No gap is required; memory may insert any latency.
- Requests from the core during the remainder of a refill are not serviced. cached_instr_valid stays 0 until IDLE, then the request is evaluated normally.
- The core must not change cached_instr_adr while req is high. Behaviour is undefined otherwise.
- Flush:
  - Clears all valid bits in the cycle after the pulse.
  - During REFILL: the outstanding refill completes on the bus (no abort) but discard=1, so the line stays invalid.
  - flush concurrent with a HIT: the HIT response still completes.
- Simultaneous flush and final refill word: flush wins; the line ends invalid.
- OFFSET_BITS=0: the refill is a single word, equivalent to a one-word line cache.
- Reset mid-refill: immediate return to IDLE and instr_req drops. Memory must tolerate an abandoned request.

Optional Feature:
- ICACHE_STATS_EN defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments on IDLE->HIT; miss_count increments on IDLE->REFILL.
  - Both are cleared by reset and by flush, and saturate at 32'hFFFFFFFF.
- Undefined: no counter ports or logic; the interface is exactly as listed above.

Decomposition:
- proc_defines.v holds `ICACHE_STATE_IDLE/HIT/REFILL (2-bit encodings) alongside the existing cache state defines.
- One sub-module: icache_data_ram (one synchronous write port, one asynchronous read port, parameterised by address width) for the data array. Tags and valids stay in the top module.

Test Plan:
- Cold miss, INDEX_BITS=4, OFFSET_BITS=2, read 0x0000_0108 (offset 2), memory latency 3 cycles:
  - instr_adr sequence 0x108, 0x10C, 0x100, 0x104.
  - cached_instr_valid with the 0x108 data coincides with the first instr_valid.
  - Line valid after the 4th word.
- Then read 0x0000_0100 -> hit: valid one cycle after req, data equals the word returned for 0x100, instr_req stays 0.
- Conflict: read 0x0000_0500 (same index 0, different tag) -> miss, refill; then 0x100 misses again.
- Flush asserted during the 2nd refill word -> all 4 words still fetched; a following read of the same address misses.
- res_n low during REFILL -> instr_req=0 and cached_instr_valid=0 immediately; after release, the same address misses.
- ICACHE_STATS_EN: 1 miss + 5 hits -> hit_count=5, miss_count=1; flush -> both 0.

Source files
------------

// File: rtl/icache_line_refill_pkg.sv
// Shared constants for the direct-mapped instruction cache: FSM encodings
// (same 2-bit values as the legacy ICACHE_STATE_* defines) and a saturating counter helper.
package icache_line_refill_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] ICACHE_STATE_IDLE   = 2'd0;
  localparam logic [1:0] ICACHE_STATE_HIT    = 2'd1;
  localparam logic [1:0] ICACHE_STATE_REFILL = 2'd2;

  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
    return (&v) ? v : v + WORD_W'(1);
  endfunction

endpackage

// File: rtl/icache_line_refill_if.sv
// Word-wide request/response channel used on both sides of the cache:
// the core-facing fetch port and the memory-facing refill port.
interface icache_line_refill_if;
  import icache_line_refill_pkg::*;

  logic              req;
  logic [WORD_W-1:0] adr;
  logic              valid;
  logic [WORD_W-1:0] read;

  modport master (output req, output adr, input valid, input read);
  modport slave  (input req, input adr, output valid, output read);
endinterface

// File: rtl/icache_data_ram.sv
// Cache data array: one synchronous write port, one asynchronous read port.
module icache_data_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/icache_line_refill.sv
// Direct-mapped instruction cache with critical-word-first line refill and flush.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module icache_line_refill
  import icache_line_refill_pkg::*;
#(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 flush,
  icache_line_refill_if.slave  core,
  icache_line_refill_if.master mem
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  localparam int          NUM_LINES  = 1 << INDEX_BITS;
  localparam int          LINE_SHIFT = INDEX_BITS + OFFSET_BITS + 2;
  localparam int          TAG_W      = 32 - LINE_SHIFT;
  localparam int          CNT_W      = (OFFSET_BITS > 0) ? OFFSET_BITS : 1;
  localparam int          RAM_AW     = INDEX_BITS + OFFSET_BITS;
  localparam logic [31:0] OFF_MASK   = 32'((1 << OFFSET_BITS) - 1);
  localparam logic [31:0] LINE_MASK  = 32'((1 << (OFFSET_BITS + 2)) - 1);

  logic [1:0]            state, state_next;
  logic [NUM_LINES-1:0]  line_valid;
  logic [TAG_W-1:0]      tag_mem [NUM_LINES];
  logic [31:0]           line_base;
  logic [CNT_W-1:0]      word_cnt, start_off, cnt_next, req_off;
  logic                  first_word, discard;
  logic [INDEX_BITS-1:0] req_index, line_index;
  logic [TAG_W-1:0]      req_tag, line_tag;
  logic                  hit, start_hit, start_miss;
  logic                  refill_word, refill_last, fwd;
  logic [31:0]           refill_adr, ram_rd_data;

  assign req_index  = INDEX_BITS'(core.adr >> (OFFSET_BITS + 2));
  assign req_tag    = TAG_W'(core.adr >> LINE_SHIFT);
  assign req_off    = CNT_W'((core.adr >> 2) & OFF_MASK);
  assign line_index = INDEX_BITS'(line_base >> (OFFSET_BITS + 2));
  assign line_tag   = TAG_W'(line_base >> LINE_SHIFT);

  assign hit        = line_valid[req_index] && (tag_mem[req_index] == req_tag);
  assign start_hit  = (state == ICACHE_STATE_IDLE) && core.req && hit;
  assign start_miss = (state == ICACHE_STATE_IDLE) && core.req && !hit;

  // The counter wraps inside the line; the refill ends when it comes back to the critical word.
  assign cnt_next    = CNT_W'((32'(word_cnt) + 32'd1) & OFF_MASK);
  assign refill_word = (state == ICACHE_STATE_REFILL) && mem.valid;
  assign refill_last = refill_word && (cnt_next == start_off);
  assign fwd         = refill_word && first_word;
  assign refill_adr  = line_base | ((32'(word_cnt) & OFF_MASK) << 2);

  // NOTE: always_comb assigns every output a default first so no latch can be inferred.
  always_comb begin
    state_next = state;
    case (state)
      ICACHE_STATE_IDLE: begin
        if (start_hit)       state_next = ICACHE_STATE_HIT;
        else if (start_miss) state_next = ICACHE_STATE_REFILL;
      end
      ICACHE_STATE_HIT:      state_next = ICACHE_STATE_IDLE;
      ICACHE_STATE_REFILL:   if (refill_last) state_next = ICACHE_STATE_IDLE;
      default:               state_next = ICACHE_STATE_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state      <= ICACHE_STATE_IDLE;
      line_base  <= '0;
      word_cnt   <= '0;
      start_off  <= '0;
      first_word <= 1'b0;
      discard    <= 1'b0;
    end else begin
      state <= state_next;
      if (start_miss) begin
        line_base  <= core.adr & ~LINE_MASK;
        word_cnt   <= req_off;
        start_off  <= req_off;
        first_word <= 1'b1;
      end else if (refill_word) begin
        word_cnt   <= cnt_next;
        first_word <= 1'b0;
      end
      // A flush mid-refill lets the bus transfer finish but keeps the line from going valid.
      if (refill_last)
        discard <= 1'b0;
      else if ((state == ICACHE_STATE_REFILL) && flush)
        discard <= 1'b1;
    end
  end

  // Flush has priority over the final refill word: the line must end invalid.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)
      line_valid <= '0;
    else if (flush)
      line_valid <= '0;
    else if (refill_last && !discard)
      line_valid[line_index] <= 1'b1;
  end

  // NOTE: storage arrays carry no reset; the valid vector alone says whether contents mean anything.
  always_ff @(posedge clk) begin
    if (refill_last) tag_mem[line_index] <= line_tag;
  end

  icache_data_ram #(
    .ADDR_W (RAM_AW),
    .DATA_W (WORD_W)
  ) u_data_ram (
    .clk     (clk),
    .we      (refill_word),
    .wr_addr (RAM_AW'(refill_adr >> 2)),
    .wr_data (mem.read),
    .rd_addr (RAM_AW'(core.adr >> 2)),
    .rd_data (ram_rd_data)
  );

  assign core.valid = (state == ICACHE_STATE_HIT) || fwd;
  assign core.read  = (state == ICACHE_STATE_HIT) ? ram_rd_data : (fwd ? mem.read : '0);
  assign mem.req    = (state == ICACHE_STATE_REFILL);
  assign mem.adr    = (state == ICACHE_STATE_REFILL) ? refill_adr : '0;

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (flush) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (start_hit)  hit_count  <= sat_inc(hit_count);
      if (start_miss) miss_count <= sat_inc(miss_count);
    end
  end
`endif

endmodule

// File: tb/tb_icache_line_refill.sv
// Self-checking bench for icache_line_refill: table of fetches with a latency-3 memory model,
// plus hand-written reset-mid-refill and (with ICACHE_STATS_EN) counter sequences.
module tb_icache_line_refill;

  localparam int IB     = 4;
  localparam int OB     = 2;
  localparam int WORDS  = 1 << OB;
  localparam int LAT    = 3;
  localparam int BUDGET = 200;

  logic clk   = 1'b0;
  logic res_n = 1'b0;
  logic flush = 1'b0;

  icache_line_refill_if core_if ();
  icache_line_refill_if mem_if ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_line_refill #(
    .INDEX_BITS  (IB),
    .OFFSET_BITS (OB)
  ) dut (
    .clk        (clk),
    .res_n      (res_n),
    .flush      (flush),
    .core       (core_if),
    .mem        (mem_if)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q  [$];
  logic [31:0] adr_q [$];
  int          flush_word = -1;
  int          flush_in   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: answers LAT cycles after instr_req, checks each instr_adr against the scoreboard,
  // and owns the flush pin (pulsed after flush_in cycles or alongside refill word flush_word).
  initial begin
    int lat  = 0;
    int widx = 0;
    logic [31:0] e;
    mem_if.valid = 1'b0;
    mem_if.read  = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_if.valid = 1'b0;
      flush        = 1'b0;
      if (flush_in > 0) begin
        flush_in--;
        if (flush_in == 0) flush = 1'b1;
      end
      if (!mem_if.req) begin
        lat  = 0;
        widx = 0;
      end else if (lat == LAT - 1) begin
        lat          = 0;
        mem_if.valid = 1'b1;
        mem_if.read  = mem_word(mem_if.adr);
        if (widx == flush_word) flush = 1'b1;
        widx++;
        if (adr_q.size() == 0) begin
          check("instr_adr_unexpected", mem_if.adr, 32'hFFFF_FFFF);
        end else begin
          e = adr_q.pop_front();
          check("instr_adr", mem_if.adr, e);
        end
      end else begin
        lat++;
      end
    end
  end

  task automatic do_fetch(input logic [31:0] a, input bit exp_hit, input int fw, input int fi,
                          input string name);
    logic [31:0] base, exp_d;
    int cyc, extra;
    bit got, saw_req;
    base = a & ~32'(WORDS * 4 - 1);
    sb_q.push_back(mem_word(a & ~32'h3));
    if (!exp_hit)
      for (int k = 0; k < WORDS; k++)
        adr_q.push_back(base | 32'(((32'((a >> 2) & 32'(WORDS - 1)) + 32'(k)) % 32'(WORDS)) << 2));
    flush_word = fw;
    @(posedge clk);
    #1;
    core_if.req = 1'b1;
    core_if.adr = a;
    flush_in    = fi;
    got = 1'b0; saw_req = 1'b0; cyc = 0;
    while (!got && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (mem_if.req) saw_req = 1'b1;
      if (core_if.valid) begin
        got   = 1'b1;
        exp_d = sb_q.pop_front();
        check({name, "_data"}, core_if.read, exp_d);
        if (exp_hit) check({name, "_hit_latency"}, 32'(cyc), 32'd2);
        else         check({name, "_fwd_with_instr_valid"}, 32'(mem_if.valid), 32'd1);
      end
    end
    check({name, "_response"}, 32'(got), 32'd1);
    if (!got) void'(sb_q.pop_front());
    check({name, "_instr_req_seen"}, 32'(saw_req), 32'(!exp_hit));
    @(posedge clk);
    #1;
    core_if.req = 1'b0;
    if (!exp_hit) begin
      extra = 0; cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (core_if.valid) extra++;
      end while (mem_if.req && cyc < BUDGET);
      check({name, "_refill_done"}, 32'(mem_if.req), 32'd0);
      check({name, "_words_left"}, 32'(adr_q.size()), 32'd0);
      check({name, "_extra_valid"}, 32'(extra), 32'd0);
      adr_q.delete();
    end
    flush_word = -1;
  endtask

  typedef struct {
    logic [31:0] adr;
    bit          hit;
    int          fw;
    int          fi;
    string       name;
  } vec_t;

  vec_t vecs [15];

  initial begin
    bit saw;
    vecs[0]  = '{32'h0000_0108, 1'b0, -1, 0, "cold_miss"};
    vecs[1]  = '{32'h0000_0100, 1'b1, -1, 0, "hit_w0"};
    vecs[2]  = '{32'h0000_010C, 1'b1, -1, 0, "hit_w3"};
    vecs[3]  = '{32'h0000_0500, 1'b0, -1, 0, "conflict"};
    vecs[4]  = '{32'h0000_0100, 1'b0, -1, 0, "evicted"};
    vecs[5]  = '{32'h0000_0234, 1'b0, -1, 0, "idx3_miss"};
    vecs[6]  = '{32'h0000_0238, 1'b1, -1, 0, "idx3_hit"};
    vecs[7]  = '{32'h0000_04F0, 1'b0,  1, 0, "flush_mid"};
    vecs[8]  = '{32'h0000_0104, 1'b0, -1, 0, "after_flush"};
    vecs[9]  = '{32'h0000_04F0, 1'b0, -1, 0, "discarded"};
    vecs[10] = '{32'h0000_04FC, 1'b1, -1, 2, "hit_with_flush"};
    vecs[11] = '{32'h0000_04F4, 1'b0, -1, 0, "flushed_by_hit"};
    vecs[12] = '{32'h0000_0634, 1'b0,  3, 0, "flush_last"};
    vecs[13] = '{32'h0000_0634, 1'b0, -1, 0, "flush_last_retry"};
    vecs[14] = '{32'h0000_0638, 1'b1, -1, 0, "retry_hit"};

    core_if.req = 1'b0;
    core_if.adr = '0;
    repeat (2) @(negedge clk);
    check("rst_instr_req", 32'(mem_if.req), 32'd0);
    check("rst_instr_adr", mem_if.adr, 32'd0);
    check("rst_cached_valid", 32'(core_if.valid), 32'd0);
    check("rst_cached_read", core_if.read, 32'd0);
    @(posedge clk);
    #1;
    res_n = 1'b1;

    foreach (vecs[i])
      do_fetch(vecs[i].adr, vecs[i].hit, vecs[i].fw, vecs[i].fi, vecs[i].name);

    // Reset while a refill is outstanding: outputs drop at once, valids are lost.
    @(posedge clk);
    #1;
    core_if.req = 1'b1;
    core_if.adr = 32'h0000_07C0;
    saw = 1'b0;
    for (int c = 0; c < BUDGET && !saw; c++) begin
      @(negedge clk);
      saw = mem_if.req;
    end
    check("rst_mid_refill_started", 32'(saw), 32'd1);
    res_n = 1'b0;
    #1;
    check("rst_mid_instr_req", 32'(mem_if.req), 32'd0);
    check("rst_mid_cached_valid", 32'(core_if.valid), 32'd0);
    core_if.req = 1'b0;
    adr_q.delete();
    @(posedge clk);
    #1;
    res_n = 1'b1;
    do_fetch(32'h0000_07C0, 1'b0, -1, 0, "post_reset_same");
    do_fetch(32'h0000_0638, 1'b0, -1, 0, "post_reset_old_line");

`ifdef ICACHE_STATS_EN
    @(posedge clk);
    #1;
    flush_in = 1;
    repeat (2) @(negedge clk);
    check("stats_clear_hit", hit_count, 32'd0);
    check("stats_clear_miss", miss_count, 32'd0);
    do_fetch(32'h0000_0780, 1'b0, -1, 0, "stats_miss");
    do_fetch(32'h0000_0784, 1'b1, -1, 0, "stats_hit1");
    do_fetch(32'h0000_0788, 1'b1, -1, 0, "stats_hit2");
    do_fetch(32'h0000_078C, 1'b1, -1, 0, "stats_hit3");
    do_fetch(32'h0000_0780, 1'b1, -1, 0, "stats_hit4");
    do_fetch(32'h0000_0784, 1'b1, -1, 0, "stats_hit5");
    @(negedge clk);
    check("stats_hit_count", hit_count, 32'd5);
    check("stats_miss_count", miss_count, 32'd1);
    @(posedge clk);
    #1;
    flush_in = 1;
    repeat (2) @(negedge clk);
    check("stats_flush_hit", hit_count, 32'd0);
    check("stats_flush_miss", miss_count, 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
